// File: rtl/ubcd_pkg.sv
// Shared types and sizing helpers for the universal BCD encoder/decoder blocks.
package ubcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ubcd_state_e;

  // Decimal digits needed to hold any bin_w-bit unsigned value: ceil(bin_w*log10(2)).
  function automatic int unsigned bcd_digits_for(input int unsigned bin_w);
    return (bin_w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/ubcd_digit_adjust.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the next shift.
module ubcd_digit_adjust
  import ubcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] digit_adj_c
);

  assign digit_adj_c = (digit >= BCD_DIGIT_W'(5)) ? (digit + BCD_DIGIT_W'(3)) : digit;

endmodule

// File: rtl/ubcd_bin_to_bcd_encoder.sv
// Sequential binary-to-packed-BCD encoder (shift-and-add-3), one input bit per clock
// under a start/busy/done handshake.
module ubcd_bin_to_bcd_encoder
  import ubcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = bcd_digits_for(BIN_W)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          overflow
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;

  ubcd_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic               busy_d, done_d, overflow_d;
  logic [BCD_W-1:0]   bcd_d;

  logic [BCD_W-1:0]   scratch_adj_c;
  logic [BCD_W-1:0]   scratch_shift_c;
  logic [BIN_W-1:0]   shift_shift_c;
  logic               carry_c;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    ubcd_digit_adjust u_adj (
      .digit       (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_adj_c (scratch_adj_c[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // One step: adjusted {carry, scratch, shift} shifted left by one.
  assign carry_c         = scratch_adj_c[BCD_W-1];
  assign scratch_shift_c = {scratch_adj_c[BCD_W-2:0], shift_q[BIN_W-1]};
  assign shift_shift_c   = shift_q << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      ovf_acc_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd_out   <= '0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      ovf_acc_q <= ovf_acc_d;
      busy      <= busy_d;
      done      <= done_d;
      bcd_out   <= bcd_d;
      overflow  <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    ovf_acc_d  = ovf_acc_q;
    bcd_d      = bcd_out;
    overflow_d = overflow;

    case (state_q)
      IDLE, DONE: begin
        // A start in the done cycle is accepted, so conversions can chain without a gap.
        if (start) begin
          state_d   = SHIFT;
          shift_d   = bin_in;
          scratch_d = '0;
          ovf_acc_d = 1'b0;
          cnt_d     = CNT_W'(BIN_W - 1);
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        shift_d   = shift_shift_c;
        scratch_d = scratch_shift_c;
        ovf_acc_d = ovf_acc_q | carry_c;
        if (cnt_q == '0) begin
          state_d    = DONE;
          bcd_d      = scratch_shift_c;
          overflow_d = ovf_acc_q | carry_c;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_ubcd_bin_to_bcd_encoder.sv
// Directed-vector bench for the shift-and-add-3 encoder (16-bit with 5 and 4 digits).
module tb_ubcd_bin_to_bcd_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start5 = 1'b0, start4 = 1'b0;
  logic [15:0] bin5 = '0, bin4 = '0;
  logic        busy5, done5, ovf5;
  logic        busy4, done4, ovf4;
  logic [19:0] bcd5;
  logic [15:0] bcd4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ubcd_bin_to_bcd_encoder #(.BIN_W(16), .DIGITS(5)) u_dut5 (
    .clk(clk), .rst(rst), .start(start5), .bin_in(bin5),
    .busy(busy5), .done(done5), .bcd_out(bcd5), .overflow(ovf5)
  );

  ubcd_bin_to_bcd_encoder #(.BIN_W(16), .DIGITS(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .bin_in(bin4),
    .busy(busy4), .done(done4), .bcd_out(bcd4), .overflow(ovf4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for done on the 5-digit instance, counting edges.
  task automatic wait_done5(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done5 && cyc < 60);
  endtask

  // Full conversion on one instance: latency, busy length, result, overflow, pulse width.
  task automatic conv(input bit sel4, input logic [15:0] val, input logic [19:0] exp_bcd,
                      input logic exp_ovf, input string tag);
    int cyc;
    int busy_cnt;
    @(posedge clk); #1;
    if (sel4) begin bin4 = val; start4 = 1'b1; end
    else      begin bin5 = val; start5 = 1'b1; end
    @(posedge clk); #1;
    start4 = 1'b0;
    start5 = 1'b0;
    busy_cnt = (sel4 ? busy4 : busy5) ? 1 : 0;
    cyc = 0;
    while (cyc < 40 && !(sel4 ? done4 : done5)) begin
      @(posedge clk); #1;
      cyc++;
      if (sel4 ? busy4 : busy5) busy_cnt++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd16);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd16);
    check({tag, "_bcd"}, sel4 ? 32'(bcd4) : 32'(bcd5), 32'(exp_bcd));
    check({tag, "_ovf"}, 32'(sel4 ? ovf4 : ovf5), 32'(exp_ovf));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(sel4 ? done4 : done5), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int busy_cnt;
    int done_cnt;

    #12;
    check("rst_busy", 32'(busy5), 32'd0);
    check("rst_done", 32'(done5), 32'd0);
    check("rst_bcd", 32'(bcd5), 32'd0);
    check("rst_ovf", 32'(ovf5), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    conv(1'b0, 16'd0,     20'h00000, 1'b0, "zero");
    conv(1'b0, 16'hFFFF,  20'h65535, 1'b0, "max");
    conv(1'b0, 16'd1234,  20'h01234, 1'b0, "d1234");
    conv(1'b1, 16'd10000, 20'h00000, 1'b1, "d4_10000");
    conv(1'b1, 16'd9999,  20'h09999, 1'b0, "d4_9999");

    // start held high: each operand taken at its accept edge, which is the done cycle.
    @(posedge clk); #1;
    bin5 = 16'd42; start5 = 1'b1;
    @(posedge clk); #1;
    bin5 = 16'd99;
    wait_done5(cyc);
    check("b2b_lat0", 32'(cyc), 32'd16);
    check("b2b_bcd0", 32'(bcd5), 32'h00042);
    @(posedge clk); #1;
    bin5 = 16'd100;
    check("b2b_busy_after_done", 32'(busy5), 32'd1);
    check("b2b_hold_bcd", 32'(bcd5), 32'h00042);
    wait_done5(cyc);
    check("b2b_lat1", 32'(cyc), 32'd16);
    check("b2b_bcd1", 32'(bcd5), 32'h00099);
    @(posedge clk); #1;
    start5 = 1'b0;
    wait_done5(cyc);
    check("b2b_lat2", 32'(cyc), 32'd16);
    check("b2b_bcd2", 32'(bcd5), 32'h00100);
    @(posedge clk); #1;

    // Start pulsed mid-conversion with another operand must be ignored.
    @(posedge clk); #1;
    bin5 = 16'd1234; start5 = 1'b1;
    @(posedge clk); #1;
    start5 = 1'b0;
    busy_cnt = busy5 ? 1 : 0;
    cyc = 0;
    while (cyc < 40 && !done5) begin
      @(posedge clk); #1;
      cyc++;
      if (busy5) busy_cnt++;
      if (cyc == 5) begin bin5 = 16'd7777; start5 = 1'b1; end
      if (cyc == 6) start5 = 1'b0;
    end
    check("ign_latency", 32'(cyc), 32'd16);
    check("ign_busy_cycles", 32'(busy_cnt), 32'd16);
    check("ign_bcd", 32'(bcd5), 32'h01234);
    @(posedge clk); #1;
    check("ign_idle_after", 32'(busy5), 32'd0);

    // Asynchronous reset in the middle of a conversion.
    bin5 = 16'd777; start5 = 1'b1;
    @(posedge clk); #1;
    start5 = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    check("arst_pre_busy", 32'(busy5), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy5), 32'd0);
    check("arst_done", 32'(done5), 32'd0);
    check("arst_bcd", 32'(bcd5), 32'd0);
    check("arst_ovf", 32'(ovf5), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done5) done_cnt++;
    end
    check("arst_no_done", 32'(done_cnt), 32'd0);
    conv(1'b0, 16'd500, 20'h00500, 1'b0, "post_rst_500");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
